// File: rtl/shift_chain_arbiter.sv
// Round-robin arbiter sharing one DEPTH-stage serial shift chain between two requesters.
// The granted word is shifted in MSB-first and reassembled on par_out with a done pulse.
module shift_chain_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [DEPTH-1:0] data0,
  input  logic [DEPTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             ser_out,
  output logic [DEPTH-1:0] par_out,
  output logic             done
);
  localparam int CW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [DEPTH-1:0] chain, ld_reg, chain_nxt;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             pick0;

  // Requester 0 wins when alone, or on a tie when requester 1 was served last.
  assign pick0     = req0 & (~req1 | last);
  assign chain_nxt = {chain[DEPTH-2:0], ld_reg[DEPTH-1]};
  assign ser_out   = chain[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      chain   <= '0;
      par_out <= '0;
      ld_reg  <= '0;
      cnt     <= '0;
      last    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt0   <= pick0;
            gnt1   <= ~pick0;
            busy   <= 1'b1;
            ld_reg <= pick0 ? data0 : data1;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          chain  <= chain_nxt;
          ld_reg <= ld_reg << 1;
          // cnt holds at DEPTH-1 on the final shift so it never wraps.
          if (cnt == CW'(DEPTH-1)) begin
            par_out <= chain_nxt;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          last  <= gnt1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/shift_chain_arbiter.md
Name: shift_chain_arbiter

Overview:
- Shares one serial shift chain of DEPTH flip-flops between two requesters using round-robin arbitration.
- Serializes the granted requester's parallel word into the chain MSB-first. The chain is a nonblocking register pipeline: each stage takes the previous stage's value.
- Reports the reassembled word on par_out with a one-cycle done pulse.
- Acts as the sequencer in front of the lab's register-pipeline datapaths.

Parameters:
- DEPTH, 4, number of chain stages and word width; legal range DEPTH >= 2.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 wants a transfer.
- req1  input  1  requester 1 wants a transfer.
- data0  input  DEPTH  requester 0 word; sampled only at its grant edge.
- data1  input  DEPTH  requester 1 word; sampled only at its grant edge.
- gnt0  output  1  requester 0 owns the chain (registered).
- gnt1  output  1  requester 1 owns the chain (registered).
- busy  output  1  a transfer is in progress (registered).
- ser_out  output  1  last chain stage, chain[DEPTH-1].
- par_out  output  DEPTH  last completed word; held until the next done.
- done  output  1  one-cycle pulse when par_out is updated.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (clk and rst named as in the codebase): all of the following take effect immediately on rst, without waiting for a clock edge.
  - state=IDLE.
  - gnt0=gnt1=busy=done=0.
  - chain=0, so ser_out=0.
  - par_out=0, ld_reg=0, cnt=0.
  - last=1, so requester 0 wins the first tie.
- State machine states: IDLE, SHIFT, DONE.
- IDLE, edge E0:
  - Only req0 set: grant 0. Only req1 set: grant 1.
  - Both set: grant the requester other than last.
  - On a grant: gnt0 or gnt1 <=1, busy<=1, ld_reg<=that requester's data, cnt<=0, state<=SHIFT.
  - No request: remain in IDLE; all outputs held.
- SHIFT, edges E1..E_DEPTH:
  - chain<={chain[DEPTH-2:0], ld_reg[DEPTH-1]}.
  - ld_reg<=ld_reg<<1.
  - cnt<=cnt+1; cnt is $clog2(DEPTH) bits wide and never wraps.
- Final shift, edge E_DEPTH (shift taken with cnt==DEPTH-1):
  - par_out<=the new chain value, which equals the granted word.
  - done<=1, state<=DONE.
- DONE, edge E_DEPTH+1:
  - done<=0, gnt0 and gnt1 <=0, busy<=0.
  - last<=index of the requester just served, state<=IDLE.
- Latency and spacing:
  - gnt is high from E0 to E_DEPTH+1, i.e. DEPTH+1 cycles.
  - done is high in the cycle between E_DEPTH and E_DEPTH+1, overlapping gnt.
  - Earliest next grant is at E_DEPTH+2, so one IDLE cycle always separates transfers.
- Handshake rules:
  - req is evaluated only in IDLE.
  - Dropping req during SHIFT or DONE does not abort; the transfer completes.
  - A data change after E0 has no effect on the transfer in progress.
- Invariants:
  - gnt0 and gnt1 are never both 1.
  - busy == (gnt0 | gnt1) at all times.
  - chain contents persist after a transfer until the next one starts shifting.
- Reset mid-operation:
  - All state returns to the reset values; no done is issued.
  - The word being transferred is lost.
  - last returns to 1.

Test Plan:
All scenarios use DEPTH=4.
- Reset: assert rst between clock edges -> all outputs 0 immediately; after release with no req, IDLE persists and outputs stay 0.
- req0=1, data0=4'b1011, single transfer:
  - gnt0=1, busy=1 after E0.
  - chain after E1..E4 = 0001, 0010, 0101, 1011.
  - ser_out = 0, 0, 0, 1.
  - done=1 and par_out=1011 after E4.
  - gnt0=busy=done=0 after E5.
- Tie, req0 and req1 held from reset, data0=1100, data1=0011:
  - gnt0 at E0; par_out=1100 at E4.
  - gnt1 at E6; par_out=0011 at E10.
  - Then gnt0 again at E12.
- req1 alone held continuously, data1=0110: grants at E0, E6, E12; each done shows 0110; exactly one IDLE cycle between transfers.
- req0 pulsed for one cycle only, data0=1001: full transfer still completes; par_out=1001 with one done pulse; no second grant follows.
- rst during SHIFT after E2 of a transfer:
  - Immediately: gnt, busy, chain and par_out are 0; done never pulses.
  - After release with req0=req1=1, gnt0 wins.
